// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: walks an active-low row strobe, debounces column samples on
// scan ticks and emits one key event per physical press, keeping the last two keys.
`timescale 1ns/1ps
module keypad_scanner #(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols_in,
  output logic [3:0] rows_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [7:0] value
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cols_s1_q, cols_s2_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       pat_q, pat_d;
  logic [3:0]       code_q, code_d;
  logic [3:0]       key_code_q, key_code_d;
  logic [7:0]       value_q, value_d;
  logic             valid_q, valid_d;
  logic             tick;
  logic             any_low;

  // Lowest-index low column wins when several are pressed together.
  function automatic logic [1:0] low_col(input logic [3:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (!cols[c]) idx = 2'(c);
    end
    return idx;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  assign tick    = (div_q == DIV_LAST);
  assign any_low = ~&cols_s2_q;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    pat_d      = pat_q;
    code_d     = code_q;
    key_code_d = key_code_q;
    value_d    = value_q;
    valid_d    = 1'b0;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (any_low) begin
            pat_d   = cols_s2_q;
            code_d  = key_map(row_q, low_col(cols_s2_q));
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            row_d = row_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (cols_s2_q == pat_q) begin
            if (cnt_q == CNT_LAST) begin
              key_code_d = code_q;
              value_d    = {value_q[3:0], code_q};
              valid_d    = 1'b1;
              state_d    = HELD;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            row_d   = row_q + 2'd1;
            state_d = SCAN;
          end
        end
        HELD: begin
          if (!any_low) begin
            cnt_d   = '0;
            state_d = RELEASE;
          end
        end
        default: begin
          // A column dropping low again is bounce on the same key, never a new event.
          if (any_low) begin
            cnt_d   = '0;
            state_d = HELD;
          end else if (cnt_q == CNT_LAST) begin
            row_d   = row_q + 2'd1;
            state_d = SCAN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SCAN;
      cols_s1_q  <= 4'hF;
      cols_s2_q  <= 4'hF;
      div_q      <= '0;
      row_q      <= 2'd0;
      cnt_q      <= '0;
      key_code_q <= 4'h0;
      value_q    <= 8'h00;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cols_s1_q  <= cols_in;
      cols_s2_q  <= cols_s1_q;
      div_q      <= tick ? '0 : div_q + DIV_W'(1);
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      key_code_q <= key_code_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
    end
  end

  // Candidate pattern/code are only read after being written in SCAN.
  always_ff @(posedge clk) begin
    pat_q  <= pat_d;
    code_q <= code_d;
  end

  assign rows_out  = ~(4'b0001 << row_q);
  assign key_code  = key_code_q;
  assign key_valid = valid_q;
  assign key_held  = (state_q == HELD) || (state_q == RELEASE);
  assign value     = value_q;

endmodule
